// File: rtl/hazard_detection_if.sv
// Hazard unit pipeline-side bundle.
// Register tags, enables, select codes and event counters.
interface hazard_detection_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       rs1_id_ex;
  logic [4:0]       rs2_id_ex;
  logic [4:0]       rd_ex_mem;
  logic [4:0]       rd_mem_wb;
  logic             reg_write_ex_mem;
  logic             reg_write_mem_wb;
  logic             mem_read_id_ex;
  logic [4:0]       rd_id_ex;
  logic [4:0]       rs1_if_id;
  logic [4:0]       rs2_if_id;
  logic             branch_ex_mem;
  logic             jump_ex_mem;
  logic             branch_taken;
  logic [1:0]       forward_A;
  logic [1:0]       forward_B;
  logic             pc_write;
  logic             retain_if_id;
  logic             flush_if_id;
  logic             flush_id_ex;
  logic             flush_ex_mem;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output rs1_id_ex, rs2_id_ex,
    output rd_ex_mem, rd_mem_wb,
    output reg_write_ex_mem, reg_write_mem_wb,
    output mem_read_id_ex, rd_id_ex,
    output rs1_if_id, rs2_if_id,
    output branch_ex_mem, jump_ex_mem,
    output branch_taken,
    input  forward_A, forward_B,
    input  pc_write, retain_if_id,
    input  flush_if_id, flush_id_ex,
    input  flush_ex_mem,
    input  stall_count, flush_count
  );

  modport slave (
    input  rs1_id_ex, rs2_id_ex,
    input  rd_ex_mem, rd_mem_wb,
    input  reg_write_ex_mem, reg_write_mem_wb,
    input  mem_read_id_ex, rd_id_ex,
    input  rs1_if_id, rs2_if_id,
    input  branch_ex_mem, jump_ex_mem,
    input  branch_taken,
    output forward_A, forward_B,
    output pc_write, retain_if_id,
    output flush_if_id, flush_id_ex,
    output flush_ex_mem,
    output stall_count, flush_count
  );
endinterface

// File: rtl/hazard_detection.sv
// Forwarding, load-use stall and redirect flush control.
// Saturating stall/flush event counters.
module hazard_detection #(
  parameter int CNT_W = 16
) (
  input logic              clk,
  input logic              rst_n,
  hazard_detection_if.slave hz
);

  logic mem_a, wb_a;
  logic mem_b, wb_b;
  logic load_use;
  logic redirect;

  assign mem_a = hz.reg_write_ex_mem
              && (hz.rd_ex_mem != 5'd0)
              && (hz.rd_ex_mem == hz.rs1_id_ex);
  assign wb_a  = hz.reg_write_mem_wb
              && (hz.rd_mem_wb != 5'd0)
              && (hz.rd_mem_wb == hz.rs1_id_ex);
  assign mem_b = hz.reg_write_ex_mem
              && (hz.rd_ex_mem != 5'd0)
              && (hz.rd_ex_mem == hz.rs2_id_ex);
  assign wb_b  = hz.reg_write_mem_wb
              && (hz.rd_mem_wb != 5'd0)
              && (hz.rd_mem_wb == hz.rs2_id_ex);

  assign load_use = hz.mem_read_id_ex
                 && (hz.rd_id_ex != 5'd0)
                 && ((hz.rd_id_ex == hz.rs1_if_id)
                  || (hz.rd_id_ex == hz.rs2_if_id));

  assign redirect = hz.branch_taken | hz.jump_ex_mem;

  // Operand select: the younger MEM result beats WB.
  always_comb begin
    hz.forward_A = 2'b00;
    hz.forward_B = 2'b00;
    priority case (1'b1)
      mem_a:   hz.forward_A = 2'b10;
      wb_a:    hz.forward_A = 2'b01;
      default: hz.forward_A = 2'b00;
    endcase
    priority case (1'b1)
      mem_b:   hz.forward_B = 2'b10;
      wb_b:    hz.forward_B = 2'b01;
      default: hz.forward_B = 2'b00;
    endcase
  end

  // A redirect squashes the stalled load-use pair anyway.
  always_comb begin
    hz.pc_write     = 1'b1;
    hz.retain_if_id = 1'b0;
    hz.flush_if_id  = 1'b0;
    hz.flush_id_ex  = 1'b0;
    hz.flush_ex_mem = 1'b0;
    priority case (1'b1)
      redirect: begin
        hz.flush_if_id  = 1'b1;
        hz.flush_id_ex  = 1'b1;
        hz.flush_ex_mem = 1'b1;
      end
      load_use: begin
        hz.pc_write     = 1'b0;
        hz.retain_if_id = 1'b1;
        hz.flush_id_ex  = 1'b1;
      end
      default: ;
    endcase
  end

  // Saturating event counters; redirect excludes a stall count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hz.stall_count <= '0;
      hz.flush_count <= '0;
    end else if (redirect) begin
      if (!(&hz.flush_count))
        hz.flush_count <= hz.flush_count + 1'b1;
    end else if (load_use) begin
      if (!(&hz.stall_count))
        hz.stall_count <= hz.stall_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_detection.sv
// Directed bench for hazard_detection.
// Main instance at CNT_W=16, second at CNT_W=2 for saturation.
module tb_hazard_detection;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   exp_stall;
  int   exp_flush;

  hazard_detection_if #(.CNT_W(16)) hz ();
  hazard_detection_if #(.CNT_W(2))  hs ();

  hazard_detection #(.CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz.slave)
  );

  hazard_detection #(.CNT_W(2)) dut_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hs.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    hz.rs1_id_ex        = 5'd0;
    hz.rs2_id_ex        = 5'd0;
    hz.rd_ex_mem        = 5'd0;
    hz.rd_mem_wb        = 5'd0;
    hz.reg_write_ex_mem = 1'b0;
    hz.reg_write_mem_wb = 1'b0;
    hz.mem_read_id_ex   = 1'b0;
    hz.rd_id_ex         = 5'd0;
    hz.rs1_if_id        = 5'd0;
    hz.rs2_if_id        = 5'd0;
    hz.branch_ex_mem    = 1'b0;
    hz.jump_ex_mem      = 1'b0;
    hz.branch_taken     = 1'b0;
  endtask

  task automatic idle_sat();
    hs.rs1_id_ex        = 5'd0;
    hs.rs2_id_ex        = 5'd0;
    hs.rd_ex_mem        = 5'd0;
    hs.rd_mem_wb        = 5'd0;
    hs.reg_write_ex_mem = 1'b0;
    hs.reg_write_mem_wb = 1'b0;
    hs.mem_read_id_ex   = 1'b0;
    hs.rd_id_ex         = 5'd0;
    hs.rs1_if_id        = 5'd0;
    hs.rs2_if_id        = 5'd0;
    hs.branch_ex_mem    = 1'b0;
    hs.jump_ex_mem      = 1'b0;
    hs.branch_taken     = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (hz.stall_count !== 16'd0) begin
      failures++;
      $display("FAIL reset_stall got=%0d exp=0",
               hz.stall_count);
    end
    checks++;
    if (hz.flush_count !== 16'd0) begin
      failures++;
      $display("FAIL reset_flush got=%0d exp=0",
               hz.flush_count);
    end
    checks++;
    if ({hz.pc_write, hz.retain_if_id,
         hz.flush_if_id, hz.flush_id_ex,
         hz.flush_ex_mem} !== 5'b10000) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=10000",
               {hz.pc_write, hz.retain_if_id,
                hz.flush_if_id, hz.flush_id_ex,
                hz.flush_ex_mem});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_fwd_mem();
    @(negedge clk);
    idle();
    hz.rs1_id_ex        = 5'd5;
    hz.rd_ex_mem        = 5'd5;
    hz.reg_write_ex_mem = 1'b1;
    #1;
    checks++;
    if (hz.forward_A !== 2'b10) begin
      failures++;
      $display("FAIL fwd_mem_A got=%b exp=10",
               hz.forward_A);
    end
    checks++;
    if (hz.forward_B !== 2'b00) begin
      failures++;
      $display("FAIL fwd_mem_B got=%b exp=00",
               hz.forward_B);
    end
    checks++;
    if ({hz.pc_write, hz.flush_if_id,
         hz.flush_id_ex, hz.flush_ex_mem} !== 4'b1000) begin
      failures++;
      $display("FAIL fwd_mem_ctrl got=%b exp=1000",
               {hz.pc_write, hz.flush_if_id,
                hz.flush_id_ex, hz.flush_ex_mem});
    end
  endtask

  task automatic test_fwd_wb();
    @(negedge clk);
    idle();
    hz.rs1_id_ex        = 5'd3;
    hz.rd_mem_wb        = 5'd3;
    hz.reg_write_mem_wb = 1'b1;
    #1;
    checks++;
    if (hz.forward_A !== 2'b01) begin
      failures++;
      $display("FAIL fwd_wb_A got=%b exp=01",
               hz.forward_A);
    end
    hz.rd_ex_mem        = 5'd3;
    hz.reg_write_ex_mem = 1'b1;
    hz.rs2_id_ex        = 5'd3;
    #1;
    checks++;
    if (hz.forward_A !== 2'b10) begin
      failures++;
      $display("FAIL fwd_prio_A got=%b exp=10",
               hz.forward_A);
    end
    checks++;
    if (hz.forward_B !== 2'b10) begin
      failures++;
      $display("FAIL fwd_prio_B got=%b exp=10",
               hz.forward_B);
    end
    hz.rd_ex_mem = 5'd9;
    #1;
    checks++;
    if (hz.forward_B !== 2'b01) begin
      failures++;
      $display("FAIL fwd_wb_B got=%b exp=01",
               hz.forward_B);
    end
  endtask

  task automatic test_x0();
    @(negedge clk);
    idle();
    hz.reg_write_ex_mem = 1'b1;
    hz.reg_write_mem_wb = 1'b1;
    #1;
    checks++;
    if ({hz.forward_A, hz.forward_B} !== 4'b0000) begin
      failures++;
      $display("FAIL x0_fwd got=%b exp=0000",
               {hz.forward_A, hz.forward_B});
    end
    hz.mem_read_id_ex = 1'b1;
    #1;
    checks++;
    if (hz.pc_write !== 1'b1 || hz.flush_id_ex !== 1'b0) begin
      failures++;
      $display("FAIL x0_stall got=%b%b exp=10",
               hz.pc_write, hz.flush_id_ex);
    end
    @(negedge clk);
    idle();
  endtask

  task automatic test_load_use();
    @(negedge clk);
    idle();
    hz.mem_read_id_ex   = 1'b1;
    hz.rd_id_ex         = 5'd6;
    hz.rs1_if_id        = 5'd6;
    hz.rs1_id_ex        = 5'd5;
    hz.rd_ex_mem        = 5'd5;
    hz.reg_write_ex_mem = 1'b1;
    #1;
    checks++;
    if ({hz.pc_write, hz.retain_if_id,
         hz.flush_if_id, hz.flush_id_ex,
         hz.flush_ex_mem} !== 5'b01010) begin
      failures++;
      $display("FAIL lu_ctrl got=%b exp=01010",
               {hz.pc_write, hz.retain_if_id,
                hz.flush_if_id, hz.flush_id_ex,
                hz.flush_ex_mem});
    end
    checks++;
    if (hz.forward_A !== 2'b10) begin
      failures++;
      $display("FAIL lu_fwd got=%b exp=10",
               hz.forward_A);
    end
    repeat (3) @(negedge clk);
    exp_stall += 3;
    hz.rs1_if_id = 5'd1;
    hz.rd_id_ex  = 5'd7;
    hz.rs2_if_id = 5'd7;
    #1;
    checks++;
    if (hz.stall_count !== 16'(exp_stall)) begin
      failures++;
      $display("FAIL lu_count got=%0d exp=%0d",
               hz.stall_count, exp_stall);
    end
    checks++;
    if (hz.pc_write !== 1'b0) begin
      failures++;
      $display("FAIL lu_rs2 got=%b exp=0",
               hz.pc_write);
    end
    @(negedge clk);
    exp_stall += 1;
    hz.rd_id_ex  = 5'd0;
    hz.rs1_if_id = 5'd0;
    hz.rs2_if_id = 5'd0;
    #1;
    checks++;
    if (hz.pc_write !== 1'b1 || hz.flush_id_ex !== 1'b0) begin
      failures++;
      $display("FAIL lu_rd0 got=%b%b exp=10",
               hz.pc_write, hz.flush_id_ex);
    end
    @(negedge clk);
    #1;
    checks++;
    if (hz.stall_count !== 16'(exp_stall)) begin
      failures++;
      $display("FAIL lu_rd0_count got=%0d exp=%0d",
               hz.stall_count, exp_stall);
    end
    idle();
  endtask

  task automatic test_branch_stall();
    @(negedge clk);
    idle();
    hz.mem_read_id_ex = 1'b1;
    hz.rd_id_ex       = 5'd6;
    hz.rs1_if_id      = 5'd6;
    hz.branch_taken   = 1'b1;
    #1;
    checks++;
    if ({hz.pc_write, hz.retain_if_id,
         hz.flush_if_id, hz.flush_id_ex,
         hz.flush_ex_mem} !== 5'b10111) begin
      failures++;
      $display("FAIL br_ctrl got=%b exp=10111",
               {hz.pc_write, hz.retain_if_id,
                hz.flush_if_id, hz.flush_id_ex,
                hz.flush_ex_mem});
    end
    @(negedge clk);
    exp_flush += 1;
    idle();
    #1;
    checks++;
    if (hz.flush_count !== 16'(exp_flush)) begin
      failures++;
      $display("FAIL br_flush_cnt got=%0d exp=%0d",
               hz.flush_count, exp_flush);
    end
    checks++;
    if (hz.stall_count !== 16'(exp_stall)) begin
      failures++;
      $display("FAIL br_stall_cnt got=%0d exp=%0d",
               hz.stall_count, exp_stall);
    end
  endtask

  task automatic test_jump();
    @(negedge clk);
    idle();
    hz.jump_ex_mem = 1'b1;
    #1;
    checks++;
    if ({hz.pc_write, hz.retain_if_id,
         hz.flush_if_id, hz.flush_id_ex,
         hz.flush_ex_mem} !== 5'b10111) begin
      failures++;
      $display("FAIL jmp_ctrl got=%b exp=10111",
               {hz.pc_write, hz.retain_if_id,
                hz.flush_if_id, hz.flush_id_ex,
                hz.flush_ex_mem});
    end
    @(negedge clk);
    exp_flush += 1;
    idle();
    hz.branch_ex_mem = 1'b1;
    #1;
    checks++;
    if ({hz.pc_write, hz.retain_if_id,
         hz.flush_if_id, hz.flush_id_ex,
         hz.flush_ex_mem} !== 5'b10000) begin
      failures++;
      $display("FAIL brinfo_ctrl got=%b exp=10000",
               {hz.pc_write, hz.retain_if_id,
                hz.flush_if_id, hz.flush_id_ex,
                hz.flush_ex_mem});
    end
    @(negedge clk);
    idle();
    #1;
    checks++;
    if (hz.flush_count !== 16'(exp_flush)) begin
      failures++;
      $display("FAIL jmp_flush_cnt got=%0d exp=%0d",
               hz.flush_count, exp_flush);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    idle();
    hz.mem_read_id_ex = 1'b1;
    hz.rd_id_ex       = 5'd6;
    hz.rs1_if_id      = 5'd6;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (hz.stall_count !== 16'd0 ||
        hz.flush_count !== 16'd0) begin
      failures++;
      $display("FAIL arst_clear got=%0d/%0d exp=0/0",
               hz.stall_count, hz.flush_count);
    end
    checks++;
    if (hz.pc_write !== 1'b0 || hz.flush_id_ex !== 1'b1) begin
      failures++;
      $display("FAIL arst_comb got=%b%b exp=01",
               hz.pc_write, hz.flush_id_ex);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (hz.stall_count !== 16'd0) begin
      failures++;
      $display("FAIL arst_hold got=%0d exp=0",
               hz.stall_count);
    end
    @(negedge clk);
    exp_stall = 1;
    exp_flush = 0;
    idle();
    #1;
    checks++;
    if (hz.stall_count !== 16'(exp_stall) ||
        hz.flush_count !== 16'(exp_flush)) begin
      failures++;
      $display("FAIL arst_resume got=%0d/%0d exp=%0d/%0d",
               hz.stall_count, hz.flush_count,
               exp_stall, exp_flush);
    end
  endtask

  task automatic test_saturation();
    @(negedge clk);
    idle_sat();
    hs.branch_taken = 1'b1;
    repeat (5) @(negedge clk);
    hs.branch_taken = 1'b0;
    #1;
    checks++;
    if (hs.flush_count !== 2'd3) begin
      failures++;
      $display("FAIL sat_flush got=%0d exp=3",
               hs.flush_count);
    end
    checks++;
    if (hs.stall_count !== 2'd0) begin
      failures++;
      $display("FAIL sat_excl got=%0d exp=0",
               hs.stall_count);
    end
    hs.mem_read_id_ex = 1'b1;
    hs.rd_id_ex       = 5'd4;
    hs.rs2_if_id      = 5'd4;
    repeat (5) @(negedge clk);
    idle_sat();
    #1;
    checks++;
    if (hs.stall_count !== 2'd3 ||
        hs.flush_count !== 2'd3) begin
      failures++;
      $display("FAIL sat_stall got=%0d/%0d exp=3/3",
               hs.stall_count, hs.flush_count);
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    exp_stall = 0;
    exp_flush = 0;
    rst_n     = 1'b0;
    idle();
    idle_sat();
    test_reset();
    test_fwd_mem();
    test_fwd_wb();
    test_x0();
    test_load_use();
    test_branch_stall();
    test_jump();
    test_async_reset();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
